// File: rtl/bjx2_decode_pkg.sv
// Shared constants and the path-select type for the BJX2 decode dispatch stage.
package bjx2_decode_pkg;

    localparam logic [1:0] IXC_CT     = 2'b10;
    localparam logic [1:0] IXC_CF     = 2'b11;
    localparam logic [1:0] IUC_WX     = 2'b11;
    localparam logic [5:0] UCMD_INVOP = 6'h3F;

    typedef enum logic [1:0] {
        BZ = 2'd0,
        FZ = 2'd1,
        FC = 2'd2
    } path_e;

endpackage

// File: rtl/bjx2_jumbo_extract.sv
// Extracts jumbo-prefix payload bits from the previous instruction words.
module bjx2_jumbo_extract #(
    parameter bit ENABLE_WEXJUMBO = 1'b1
) (
    input  logic [63:0] istrWordL,
    output logic [27:0] jBits,
    output logic [27:0] jBits2
);

    logic jumbo_a;
    logic jumbo_b;

    assign jumbo_a = (istrWordL[15:8]  == 8'hFE);
    assign jumbo_b = (istrWordL[47:40] == 8'hFE);

    always_comb begin
        jBits  = '0;
        jBits2 = '0;
        if (ENABLE_WEXJUMBO) begin
            jBits[15:0]  = istrWordL[31:16];
            jBits[23:16] = istrWordL[7:0];
            jBits[24]    = jumbo_a;
            jBits[25]    = jumbo_a & jumbo_b;
            jBits[26]    = istrWordL[8];
            jBits[27]    = istrWordL[40];

            jBits2[15:0]  = istrWordL[63:48];
            jBits2[23:16] = istrWordL[39:32];
            jBits2[24]    = jumbo_b;
            jBits2[26]    = istrWordL[40];
        end
    end

endmodule

// File: rtl/bjx2_decode_dispatch.sv
// Decode dispatch: classifies the fetched word, picks a sub-decoder result,
// applies predication / WEX rules and registers the micro-op.
module bjx2_decode_dispatch
    import bjx2_decode_pkg::*;
#(
    parameter bit ENABLE_OPS16    = 1'b1,
    parameter bit ENABLE_OPS48    = 1'b1,
    parameter bit ENABLE_WEXJUMBO = 1'b1,
    parameter int GPR_W           = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [63:0]      istrWord,
    input  logic [63:0]      istrWordL,
    input  logic [GPR_W-1:0] bzRegN,
    input  logic [GPR_W-1:0] bzRegM,
    input  logic [GPR_W-1:0] bzRegO,
    input  logic [32:0]      bzImm,
    input  logic [7:0]       bzUCmd,
    input  logic [7:0]       bzUIxt,
    input  logic [GPR_W-1:0] fzRegN,
    input  logic [GPR_W-1:0] fzRegM,
    input  logic [GPR_W-1:0] fzRegO,
    input  logic [32:0]      fzImm,
    input  logic [7:0]       fzUCmd,
    input  logic [7:0]       fzUIxt,
    input  logic [3:0]       fzUFl,
    input  logic [GPR_W-1:0] fcRegN,
    input  logic [GPR_W-1:0] fcRegM,
    input  logic [GPR_W-1:0] fcRegO,
    input  logic [32:0]      fcImm,
    input  logic [7:0]       fcUCmd,
    input  logic [7:0]       fcUIxt,
    output logic [27:0]      jBits,
    output logic [27:0]      jBits2,
    output logic [GPR_W-1:0] idRegN,
    output logic [GPR_W-1:0] idRegM,
    output logic [GPR_W-1:0] idRegO,
    output logic [32:0]      idImm,
    output logic [32:0]      idImmB,
    output logic [7:0]       idUCmd,
    output logic [7:0]       idUIxt
);

    path_e            path_sel;
    logic             is_pred;
    logic             df_bit;

    logic [GPR_W-1:0] reg_n_d, reg_n_q;
    logic [GPR_W-1:0] reg_m_d, reg_m_q;
    logic [GPR_W-1:0] reg_o_d, reg_o_q;
    logic [32:0]      imm_d, imm_q;
    logic [32:0]      imm_b_d, imm_b_q;
    logic [7:0]       ucmd_d, ucmd_q;
    logic [7:0]       uixt_d, uixt_q;

    logic             unused_bits;
    assign unused_bits = ^{istrWord[63:16], istrWord[7:0], fzUFl[3:1]};

    bjx2_jumbo_extract #(
        .ENABLE_WEXJUMBO(ENABLE_WEXJUMBO)
    ) u_jumbo (
        .istrWordL(istrWordL),
        .jBits    (jBits),
        .jBits2   (jBits2)
    );

    // E-block prefixes are predicated, F-block mirrors them unpredicated.
    always_comb begin
        path_sel = BZ;
        is_pred  = 1'b0;
        df_bit   = 1'b0;
        if (istrWord[15:13] == 3'b111) begin
            is_pred = ~istrWord[12];
            if (!istrWord[11]) begin
                path_sel = FZ;
                df_bit   = istrWord[10];
            end else if (!istrWord[10]) begin
                path_sel = FZ;
                df_bit   = istrWord[8];
            end else begin
                path_sel = FC;
                df_bit   = istrWord[9];
            end
        end
        if (!ENABLE_OPS16 && (path_sel == BZ)) begin
            path_sel = FZ;
        end
        if (!ENABLE_OPS48 && (path_sel == FC)) begin
            path_sel = FZ;
        end
    end

    always_comb begin
        reg_n_d = bzRegN;
        reg_m_d = bzRegM;
        reg_o_d = bzRegO;
        imm_d   = bzImm;
        ucmd_d  = bzUCmd;
        uixt_d  = bzUIxt;
        case (path_sel)
            FZ: begin
                reg_n_d = fzRegN;
                reg_m_d = fzRegM;
                reg_o_d = fzRegO;
                imm_d   = fzImm;
                ucmd_d  = fzUCmd;
                uixt_d  = fzUIxt;
            end
            FC: begin
                reg_n_d = fcRegN;
                reg_m_d = fcRegM;
                reg_o_d = fcRegO;
                imm_d   = fcImm;
                ucmd_d  = fcUCmd;
                uixt_d  = fcUIxt;
            end
            default: ;
        endcase

        if (is_pred) begin
            ucmd_d[7:6] = df_bit ? IXC_CF : IXC_CT;
        end
        // A WEX-marked op reaching dispatch alone is invalid; keep its condition bits.
        if (uixt_d[7:6] == IUC_WX) begin
            ucmd_d[5:0] = UCMD_INVOP;
        end

        imm_b_d = '0;
        if (ENABLE_WEXJUMBO) begin
            if (fzUFl[0]) begin
                imm_b_d = {(fzImm[32] ? 9'h1FF : 9'h000), jBits2[23:0]};
            end else begin
                imm_b_d = {1'b0, jBits2[23:0], jBits[23:16]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg_n_q <= '0;
            reg_m_q <= '0;
            reg_o_q <= '0;
            imm_q   <= '0;
            imm_b_q <= '0;
            ucmd_q  <= '0;
            uixt_q  <= '0;
        end else begin
            reg_n_q <= reg_n_d;
            reg_m_q <= reg_m_d;
            reg_o_q <= reg_o_d;
            imm_q   <= imm_d;
            imm_b_q <= imm_b_d;
            ucmd_q  <= ucmd_d;
            uixt_q  <= uixt_d;
        end
    end

    assign idRegN = reg_n_q;
    assign idRegM = reg_m_q;
    assign idRegO = reg_o_q;
    assign idImm  = imm_q;
    assign idImmB = imm_b_q;
    assign idUCmd = ucmd_q;
    assign idUIxt = uixt_q;

endmodule

// File: tb/tb_bjx2_decode_dispatch.sv
// Directed + table-driven scoreboard bench for the BJX2 decode dispatch stage.
module tb_bjx2_decode_dispatch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] istrWord = '0;
    logic [63:0] istrWordL = '0;
    logic [6:0]  bzRegN = '0, bzRegM = '0, bzRegO = '0;
    logic [32:0] bzImm = '0;
    logic [7:0]  bzUCmd = '0, bzUIxt = '0;
    logic [6:0]  fzRegN = '0, fzRegM = '0, fzRegO = '0;
    logic [32:0] fzImm = '0;
    logic [7:0]  fzUCmd = '0, fzUIxt = '0;
    logic [3:0]  fzUFl = '0;
    logic [6:0]  fcRegN = '0, fcRegM = '0, fcRegO = '0;
    logic [32:0] fcImm = '0;
    logic [7:0]  fcUCmd = '0, fcUIxt = '0;
    logic [27:0] jBits, jBits2;
    logic [6:0]  idRegN, idRegM, idRegO;
    logic [32:0] idImm, idImmB;
    logic [7:0]  idUCmd, idUIxt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [6:0]  rn, rm, ro;
        logic [32:0] imm, immb;
        logic [7:0]  ucmd, uixt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clock = ~clock;

    bjx2_decode_dispatch dut (
        .clock(clock), .reset(reset),
        .istrWord(istrWord), .istrWordL(istrWordL),
        .bzRegN(bzRegN), .bzRegM(bzRegM), .bzRegO(bzRegO),
        .bzImm(bzImm), .bzUCmd(bzUCmd), .bzUIxt(bzUIxt),
        .fzRegN(fzRegN), .fzRegM(fzRegM), .fzRegO(fzRegO),
        .fzImm(fzImm), .fzUCmd(fzUCmd), .fzUIxt(fzUIxt), .fzUFl(fzUFl),
        .fcRegN(fcRegN), .fcRegM(fcRegM), .fcRegO(fcRegO),
        .fcImm(fcImm), .fcUCmd(fcUCmd), .fcUIxt(fcUIxt),
        .jBits(jBits), .jBits2(jBits2),
        .idRegN(idRegN), .idRegM(idRegM), .idRegO(idRegO),
        .idImm(idImm), .idImmB(idImmB), .idUCmd(idUCmd), .idUIxt(idUIxt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [27:0] model_jbits(input logic [63:0] wl);
        logic ja, jb;
        ja = (wl[15:8] == 8'hFE);
        jb = (wl[47:40] == 8'hFE);
        return {wl[40], wl[8], ja & jb, ja, wl[7:0], wl[31:16]};
    endfunction

    function automatic logic [27:0] model_jbits2(input logic [63:0] wl);
        return {1'b0, wl[40], 1'b0, (wl[47:40] == 8'hFE), wl[39:32], wl[63:48]};
    endfunction

    // Reference decode, keyed on prefix byte ranges.
    function automatic exp_t model_decode();
        exp_t e;
        logic [7:0] b;
        logic pred, df;
        int sel; // 0 bz, 1 fz, 2 fc
        logic [27:0] jb, jb2;
        b = istrWord[15:8];
        pred = 1'b0; df = 1'b0; sel = 0;
        if (b >= 8'hE0 && b <= 8'hE7)      begin sel = 1; pred = 1'b1; df = b[2]; end
        else if (b >= 8'hE8 && b <= 8'hEB) begin sel = 1; pred = 1'b1; df = b[0]; end
        else if (b >= 8'hEC && b <= 8'hEF) begin sel = 2; pred = 1'b1; df = b[1]; end
        else if (b >= 8'hF0 && b <= 8'hFB) sel = 1;
        else if (b >= 8'hFC)               sel = 2;
        if (sel == 0) begin
            e.rn = bzRegN; e.rm = bzRegM; e.ro = bzRegO; e.imm = bzImm; e.ucmd = bzUCmd; e.uixt = bzUIxt;
        end else if (sel == 1) begin
            e.rn = fzRegN; e.rm = fzRegM; e.ro = fzRegO; e.imm = fzImm; e.ucmd = fzUCmd; e.uixt = fzUIxt;
        end else begin
            e.rn = fcRegN; e.rm = fcRegM; e.ro = fcRegO; e.imm = fcImm; e.ucmd = fcUCmd; e.uixt = fcUIxt;
        end
        if (pred) e.ucmd[7:6] = df ? 2'b11 : 2'b10;
        if (e.uixt[7:6] == 2'b11) e.ucmd[5:0] = 6'h3F;
        jb  = model_jbits(istrWordL);
        jb2 = model_jbits2(istrWordL);
        if (fzUFl[0]) e.immb = {{9{fzImm[32]}}, jb2[23:0]};
        else          e.immb = {1'b0, jb2[23:0], jb[23:16]};
        return e;
    endfunction

    task automatic rand_inputs();
        istrWord  = {$urandom, $urandom};
        istrWordL = {$urandom, $urandom};
        bzRegN = 7'($urandom); bzRegM = 7'($urandom); bzRegO = 7'($urandom);
        fzRegN = 7'($urandom); fzRegM = 7'($urandom); fzRegO = 7'($urandom);
        fcRegN = 7'($urandom); fcRegM = 7'($urandom); fcRegO = 7'($urandom);
        bzImm = {1'($urandom), 32'($urandom)};
        fzImm = {1'($urandom), 32'($urandom)};
        fcImm = {1'($urandom), 32'($urandom)};
        bzUCmd = 8'($urandom); bzUIxt = 8'($urandom);
        fzUCmd = 8'($urandom); fzUIxt = 8'($urandom);
        fcUCmd = 8'($urandom); fcUIxt = 8'($urandom);
        fzUFl  = 4'($urandom);
    endtask

    // Drive is already done; check jumbo bits, push expectation, clock, pop and compare.
    task automatic step(input string tag);
        exp_t e;
        #1;
        chk({tag, ".jBits"},  {36'b0, jBits},  {36'b0, model_jbits(istrWordL)});
        chk({tag, ".jBits2"}, {36'b0, jBits2}, {36'b0, model_jbits2(istrWordL)});
        exp_q.push_back(model_decode());
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".idRegN"}, {57'b0, idRegN}, {57'b0, e.rn});
        chk({tag, ".idRegM"}, {57'b0, idRegM}, {57'b0, e.rm});
        chk({tag, ".idRegO"}, {57'b0, idRegO}, {57'b0, e.ro});
        chk({tag, ".idImm"},  {31'b0, idImm},  {31'b0, e.imm});
        chk({tag, ".idImmB"}, {31'b0, idImmB}, {31'b0, e.immb});
        chk({tag, ".idUCmd"}, {56'b0, idUCmd}, {56'b0, e.ucmd});
        chk({tag, ".idUIxt"}, {56'b0, idUIxt}, {56'b0, e.uixt});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".zero"}, {idRegN, idRegM, idRegO, idImm}, 64'h0);
        chk({tag, ".zeroB"}, {15'b0, idImmB, idUCmd, idUIxt}, 64'h0);
    endtask

    logic [7:0] pfx_tab [12] = '{8'hE0, 8'hE3, 8'hE4, 8'hE8, 8'hEA, 8'hEB,
                                 8'hEC, 8'hEF, 8'hF2, 8'hF9, 8'hFE, 8'h30};

    initial begin
        rand_inputs();
        #12;
        chk_zero("reset_hold");
        @(negedge clock);
        reset = 1'b1;

        // Bz select
        rand_inputs();
        istrWord[15:0] = 16'h3012; bzUCmd = 8'h05; bzImm = 33'h7; bzUIxt = 8'h00;
        step("bz_sel");
        chk("bz_ucmd_const", {56'b0, idUCmd}, 64'h05);
        chk("bz_imm_const", {31'b0, idImm}, 64'h7);

        // Predicated Fz
        rand_inputs(); istrWord[15:8] = 8'hE4; fzUCmd = 8'h0A; fzUIxt = 8'h01;
        step("fz_e4");
        chk("fz_e4_const", {56'b0, idUCmd}, 64'hCA);
        rand_inputs(); istrWord[15:8] = 8'hE0; fzUCmd = 8'h0A; fzUIxt = 8'h01;
        step("fz_e0");
        chk("fz_e0_const", {56'b0, idUCmd}, 64'h8A);
        rand_inputs(); istrWord[15:8] = 8'hF4; fzUCmd = 8'h0A; fzUIxt = 8'h01;
        step("fz_f4");
        chk("fz_f4_const", {56'b0, idUCmd}, 64'h0A);

        // FC select
        rand_inputs(); istrWord[15:8] = 8'hEE; fcUIxt = 8'h00;
        step("fc_ee");
        chk("fc_ee_cc", {62'b0, idUCmd[7:6]}, 64'h3);
        rand_inputs(); istrWord[15:8] = 8'hFD; fcUCmd = 8'h45; fcUIxt = 8'h12;
        step("fc_fd");
        chk("fc_fd_const", {56'b0, idUCmd}, 64'h45);

        // WEX invalid
        rand_inputs(); istrWord[15:8] = 8'hF0; fzUCmd = 8'h05; fzUIxt = 8'hC0;
        step("wex_f0");
        chk("wex_const", {56'b0, idUCmd}, 64'h3F);

        // Jumbo extraction and 64-bit immB form
        rand_inputs(); istrWordL = 64'h1234_56FE_ABCD_FE99; istrWord[15:8] = 8'hF1;
        fzUFl = 4'b0001; fzImm = 33'h1_0000_0000;
        #1;
        chk("jbits_const",  {36'b0, jBits},  64'h199ABCD);
        chk("jbits2_const", {36'b0, jBits2}, 64'h0FE1234);
        step("jumbo_a");
        chk("immb_sign", {55'b0, idImmB[32:24]}, 64'h1FF);
        rand_inputs(); istrWordL = 64'h00FE_FE00_0000_FE00; fzUFl = 4'b0000;
        step("jumbo_ab");
        chk("jbits_ab", {62'b0, jBits[25:24]}, 64'h3);

        // Mid-stream reset clears outputs without a clock edge
        rand_inputs(); istrWord[15:8] = 8'hE9;
        step("pre_reset");
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clock);
        reset = 1'b1;
        rand_inputs(); istrWord[15:8] = 8'hEB;
        step("post_reset");

        // Table-driven sweep over prefix classes
        for (int i = 0; i < 36; i++) begin
            rand_inputs();
            istrWord[15:8] = pfx_tab[i % 12];
            step($sformatf("sweep%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
